// File: rtl/lisnoc_ring_pkg.sv
// Shared LISNoC ring definitions: flit type codes, packetizer state encoding
// and the header-flit packing helper.
package lisnoc_ring_pkg;

  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Destination sits in the top pdw bits of the data field, length in the low lw bits.
  function automatic logic [63:0] pack_header(input logic [63:0] dest, input logic [63:0] len,
                                              input int fdw, input int pdw, input int lw);
    logic [63:0] dmask;
    logic [63:0] lmask;
    dmask = (64'd1 << pdw) - 64'd1;
    lmask = (64'd1 << lw) - 64'd1;
    return ((dest & dmask) << (fdw - pdw)) | (len & lmask);
  endfunction

endpackage

// File: rtl/lisnoc_ring_packetizer.sv
// Turns descriptor + payload-word messages into LISNoC flits for the local
// input port of a unidirectional ring router; bad destinations are drained.
module lisnoc_ring_packetizer
  import lisnoc_ring_pkg::*;
#(
  parameter int num_dests       = 5,
  parameter int flit_data_width = 16,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int len_width       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ph_dest_width-1:0]                   desc_dest,
  input  logic [len_width-1:0]                       desc_len,
  input  logic                                       desc_valid,
  output logic                                       desc_ready,
  input  logic [flit_data_width-1:0]                 data_in,
  input  logic                                       data_valid,
  output logic                                       data_ready,
  output logic [flit_data_width+flit_type_width-1:0] out_flit,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy,
  output logic                                       err_dest
);

  localparam int FW = flit_data_width + flit_type_width;
  localparam logic [ph_dest_width-1:0] DEST_LIMIT = ph_dest_width'(num_dests);

  state_e                 state_q, state_d;
  logic [len_width-1:0]   rem_q, rem_d;
  logic                   out_valid_q, out_valid_d;
  logic [FW-1:0]          out_flit_q, out_flit_d;
  logic [FW-1:0]          hdr_q, hdr_d;
  logic                   err_q, err_d;
  logic                   out_free;
  logic [flit_data_width-1:0] hdr_data;
  logic [FW-1:0]          hdr_flit;

  assign out_free = !out_valid_q || out_ready;
  assign hdr_data = flit_data_width'(pack_header(64'(desc_dest), 64'(desc_len),
                                                 flit_data_width, ph_dest_width, len_width));
  assign hdr_flit = (desc_len == '0) ? {flit_type_width'(FLIT_SINGLE), hdr_data}
                                     : {flit_type_width'(FLIT_HEADER), hdr_data};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    hdr_d       = hdr_q;
    err_d       = 1'b0;
    desc_ready  = 1'b0;
    data_ready  = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        desc_ready = out_free;
        if (desc_valid && desc_ready) begin
          rem_d = desc_len;
          if (desc_dest >= DEST_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end else if (out_free) begin
            out_valid_d = 1'b1;
            out_flit_d  = hdr_flit;
            state_d     = (desc_len == '0) ? ST_IDLE : ST_PAY;
          end else begin
            hdr_d   = hdr_flit;
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_flit_d  = hdr_q;
          state_d     = (rem_q == '0) ? ST_IDLE : ST_PAY;
        end
      end
      ST_PAY: begin
        data_ready = out_free;
        if (data_valid && data_ready) begin
          out_valid_d = 1'b1;
          out_flit_d  = (rem_q == len_width'(1)) ? {flit_type_width'(FLIT_LAST), data_in}
                                                 : {flit_type_width'(FLIT_PAYLOAD), data_in};
          rem_d = rem_q - len_width'(1);
          if (rem_q == len_width'(1)) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        // A zero-length drop owns no words, so it must not swallow the next message's data.
        data_ready = (rem_q != '0);
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end else if (data_valid) begin
          rem_d = rem_q - len_width'(1);
          if (rem_q == len_width'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
  end

  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign err_dest  = err_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_lisnoc_ring_packetizer.sv
// Directed bench for lisnoc_ring_packetizer: hand-computed flits per scenario.
module tb_lisnoc_ring_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  desc_dest;
  logic [7:0]  desc_len;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [17:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err_dest;

  int tests_run = 0;
  int failed    = 0;

  lisnoc_ring_packetizer dut (
    .clk(clk), .rst(rst),
    .desc_dest(desc_dest), .desc_len(desc_len), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_dest(err_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; desc_dest = '0; desc_len = '0; desc_valid = 1'b0;
    data_in = '0; data_valid = 1'b0; out_ready = 1'b1;
    #3;
    tests_run++;
    if ({out_valid, out_flit, busy, err_dest} !== 21'd0) begin
      failed++;
      $display("FAIL reset_outputs: got v=%b f=%h busy=%b err=%b, want all 0", out_valid, out_flit, busy, err_dest);
    end
    tests_run++;
    if ({desc_ready, data_ready} !== 2'b10) begin
      failed++;
      $display("FAIL reset_readys: got desc_ready=%b data_ready=%b, want 1 0", desc_ready, data_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    desc_dest = 5'd3; desc_len = 8'd0; desc_valid = 1'b1;
    tests_run++;
    if (desc_ready !== 1'b1) begin
      failed++; $display("FAIL single_desc_ready: got %b want 1", desc_ready);
    end
    tick();
    desc_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h31800}) begin
      failed++; $display("FAIL single_flit: got v=%b f=%h want v=1 f=31800", out_valid, out_flit);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      failed++; $display("FAIL single_busy_high: got %b want 1", busy);
    end
    tick();
    tests_run++;
    if ({out_valid, busy} !== 2'b00) begin
      failed++; $display("FAIL single_done: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_packet();
    logic [17:0] exp_f [4];
    exp_f[0] = 18'h11003; exp_f[1] = 18'h0A001; exp_f[2] = 18'h0A002; exp_f[3] = 18'h2A003;
    out_ready = 1'b1;
    desc_dest = 5'd2; desc_len = 8'd3; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        data_in = 16'hA001 + 16'(i); data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      tests_run++;
      if ({out_valid, out_flit} !== {1'b1, exp_f[i]}) begin
        failed++; $display("FAIL packet_flit%0d: got v=%b f=%h want v=1 f=%h", i, out_valid, out_flit, exp_f[i]);
      end
      if (i == 0) begin
        tests_run++;
        if ({desc_ready, data_ready} !== 2'b01) begin
          failed++; $display("FAIL packet_readys: got desc=%b data=%b want 0 1", desc_ready, data_ready);
        end
      end
      tick();
    end
    tests_run++;
    if ({out_valid, busy} !== 2'b00) begin
      failed++; $display("FAIL packet_done: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp_f [4];
    logic [15:0] pattern;
    logic [17:0] held;
    logic        stalled;
    logic        d_acc, w_acc;
    int          got, sent;
    exp_f[0] = 18'h11003; exp_f[1] = 18'h0A001; exp_f[2] = 18'h0A002; exp_f[3] = 18'h2A003;
    pattern = 16'b1111_0110_1001_1001;
    got = 0; sent = 0; stalled = 1'b0; held = '0;
    desc_dest = 5'd2; desc_len = 8'd3; desc_valid = 1'b1; data_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c < 16) ? pattern[c] : 1'b1;
      #1;
      if (stalled) begin
        tests_run++;
        if ({out_valid, out_flit} !== {1'b1, held}) begin
          failed++; $display("FAIL bp_hold_c%0d: got v=%b f=%h want v=1 f=%h", c, out_valid, out_flit, held);
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (got >= 4 || out_flit !== exp_f[got]) begin
          failed++; $display("FAIL bp_flit%0d: got f=%h want %h", got, out_flit, (got < 4) ? exp_f[got] : 18'h0);
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = out_flit;
      d_acc   = desc_valid && desc_ready;
      w_acc   = data_valid && data_ready;
      tick();
      if (d_acc) begin
        desc_valid = 1'b0; data_valid = 1'b1; data_in = 16'hA001;
      end
      if (w_acc) begin
        sent++;
        if (sent < 3) data_in = 16'hA001 + 16'(sent);
        else data_valid = 1'b0;
      end
    end
    tests_run++;
    if (got !== 4) begin
      failed++; $display("FAIL bp_count: got %0d flits want 4", got);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_drop();
    out_ready = 1'b1;
    desc_dest = 5'd7; desc_len = 8'd2; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    data_in = 16'hE001; data_valid = 1'b1;
    tests_run++;
    if ({err_dest, out_valid, busy, data_ready} !== 4'b1011) begin
      failed++; $display("FAIL drop_first: got err=%b v=%b busy=%b dr=%b want 1 0 1 1", err_dest, out_valid, busy, data_ready);
    end
    tick();
    data_in = 16'hE002;
    tests_run++;
    if ({err_dest, out_valid, data_ready} !== 3'b001) begin
      failed++; $display("FAIL drop_second: got err=%b v=%b dr=%b want 0 0 1", err_dest, out_valid, data_ready);
    end
    tick();
    data_valid = 1'b0;
    tests_run++;
    if ({err_dest, out_valid, busy} !== 3'b000) begin
      failed++; $display("FAIL drop_done: got err=%b v=%b busy=%b want 0 0 0", err_dest, out_valid, busy);
    end
    desc_dest = 5'd4; desc_len = 8'd0; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_flit, err_dest} !== {1'b1, 18'h32000, 1'b0}) begin
      failed++; $display("FAIL drop_next_good: got v=%b f=%h err=%b want 1 32000 0", out_valid, out_flit, err_dest);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    desc_dest = 5'd1; desc_len = 8'd4; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    data_in = 16'hB001; data_valid = 1'b1;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h10804}) begin
      failed++; $display("FAIL rmid_header: got v=%b f=%h want 1 10804", out_valid, out_flit);
    end
    tick();
    data_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h0B001}) begin
      failed++; $display("FAIL rmid_payload: got v=%b f=%h want 1 0b001", out_valid, out_flit);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, busy, data_ready, desc_ready} !== 4'b0001) begin
      failed++; $display("FAIL rmid_in_reset: got v=%b busy=%b dr=%b descr=%b want 0 0 0 1", out_valid, busy, data_ready, desc_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, busy} !== 2'b00) begin
      failed++; $display("FAIL rmid_after_release: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    desc_dest = 5'd0; desc_len = 8'd1; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    data_in = 16'hC001; data_valid = 1'b1;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h10001}) begin
      failed++; $display("FAIL rmid_new_header: got v=%b f=%h want 1 10001", out_valid, out_flit);
    end
    tick();
    data_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h2C001}) begin
      failed++; $display("FAIL rmid_new_last: got v=%b f=%h want 1 2c001", out_valid, out_flit);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    desc_dest = 5'd1; desc_len = 8'd1; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    data_in = 16'hD001; data_valid = 1'b1;
    tests_run++;
    if ({out_valid, out_flit, desc_ready} !== {1'b1, 18'h10801, 1'b0}) begin
      failed++; $display("FAIL b2b_header: got v=%b f=%h descr=%b want 1 10801 0", out_valid, out_flit, desc_ready);
    end
    tick();
    data_valid = 1'b0;
    desc_dest = 5'd3; desc_len = 8'd0; desc_valid = 1'b1;
    tests_run++;
    if ({out_valid, out_flit, desc_ready} !== {1'b1, 18'h2D001, 1'b1}) begin
      failed++; $display("FAIL b2b_last: got v=%b f=%h descr=%b want 1 2d001 1", out_valid, out_flit, desc_ready);
    end
    tick();
    desc_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_flit} !== {1'b1, 18'h31800}) begin
      failed++; $display("FAIL b2b_single: got v=%b f=%h want 1 31800", out_valid, out_flit);
    end
    tick();
    tests_run++;
    if ({out_valid, busy} !== 2'b00) begin
      failed++; $display("FAIL b2b_done: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
